// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM states, default widths
// and the port index constants used for grant and ownership encoding.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin grant: combinational winner selection from the request
// valids and the last-grant pointer, which advances only when a grant is taken.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant,
    output logic       last_grant
);

    // On a tie the port that did not win last time goes next; a lone
    // requester always wins regardless of the pointer.
    always_comb begin
        grant = ~last_grant;
        if (valid[0] && !valid[1]) begin
            grant = PORT_FETCH;
        end else if (valid[1] && !valid[0]) begin
            grant = PORT_LSU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_LSU;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter and sequencer in front of the single-port data RAM:
// registers one access at a time onto the RAM pins and returns a one-cycle response.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    input  logic              p0_req_we,
    input  logic [15:0]       p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_req_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_data,

    input  logic              p1_req_valid,
    input  logic              p1_req_we,
    input  logic [15:0]       p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_req_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_read_data,

    output arb_state_e        dbg_state
);

    arb_state_e state;
    arb_state_e state_next;

    logic              grant;
    logic              last_grant;
    logic              accept;
    logic              can_accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              owner;
    logic              op_we;

    // Upper request address bits alias onto the same RAM word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_req_addr[15:ADDR_W], p1_req_addr[15:ADDR_W], last_grant};

    // Handshake: valid/ready, transfer on a rising edge where both are high.
    // Requesters hold valid and payload until ready; nothing is latched early.
    assign can_accept   = (state != ISSUE);
    assign p0_req_ready = can_accept && p0_req_valid && (grant == PORT_FETCH);
    assign p1_req_ready = can_accept && p1_req_valid && (grant == PORT_LSU);
    assign accept       = p0_req_ready || p1_req_ready;

    assign sel_we    = (grant == PORT_LSU) ? p1_req_we    : p0_req_we;
    assign sel_addr  = (grant == PORT_LSU) ? p1_req_addr[ADDR_W-1:0] : p0_req_addr[ADDR_W-1:0];
    assign sel_wdata = (grant == PORT_LSU) ? p1_req_wdata : p0_req_wdata;

    assign dbg_state = state;

    ram_arb_rr2 u_rr2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      ({p1_req_valid, p0_req_valid}),
        .accept     (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address and write data hold outside ISSUE so the RAM sees no spurious
    // address changes; only the write enable is pulsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr         <= '0;
            ram_write_data   <= '0;
            ram_write_enable <= 1'b0;
            owner            <= PORT_FETCH;
            op_we            <= 1'b0;
        end else begin
            ram_write_enable <= accept ? sel_we : 1'b0;
            if (accept) begin
                ram_addr       <= sel_addr;
                ram_write_data <= sel_wdata;
                owner          <= grant;
                op_we          <= sel_we;
            end
        end
    end

    // The RAM completes its access on the falling edge inside ISSUE, so its
    // read data is valid to capture on the ISSUE->RESP edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_data  <= '0;
            p1_rsp_data  <= '0;
        end else begin
            p0_rsp_valid <= (state == ISSUE) && (owner == PORT_FETCH);
            p1_rsp_valid <= (state == ISSUE) && (owner == PORT_LSU);
            if (state == ISSUE) begin
                if (owner == PORT_FETCH) begin
                    p0_rsp_data <= op_we ? '0 : ram_read_data;
                end else begin
                    p1_rsp_data <= op_we ? '0 : ram_read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: emulated falling-edge RAM, a transaction-level
// reference model of arbitration and memory contents, and scenario tasks.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req_valid = 1'b0, p0_req_we = 1'b0;
    logic [15:0]   p0_req_addr = '0;
    logic [DW-1:0] p0_req_wdata = '0;
    logic          p0_req_ready, p0_rsp_valid;
    logic [DW-1:0] p0_rsp_data;
    logic          p1_req_valid = 1'b0, p1_req_we = 1'b0;
    logic [15:0]   p1_req_addr = '0;
    logic [DW-1:0] p1_req_wdata = '0;
    logic          p1_req_ready, p1_rsp_valid;
    logic [DW-1:0] p1_rsp_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_write_data;
    logic          ram_write_enable;
    logic [DW-1:0] ram_read_data = '0;
    arb_state_e    dbg_state;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .ram_write_enable(ram_write_enable), .ram_read_data(ram_read_data),
        .dbg_state(dbg_state)
    );

    // RAM acts on the falling edge: read-before-write, registered read data.
    logic          init_ram = 1'b0;
    logic [DW-1:0] tb_ram [0:1023];
    always @(negedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 1024; i++) tb_ram[i] <= '0;
            tb_ram[5] <= 16'hBEEF;
        end else begin
            if (ram_write_enable) tb_ram[ram_addr] <= ram_write_data;
            ram_read_data <= tb_ram[ram_addr];
        end
    end

    // Reference model: memory contents, last winner, and a two-slot view of
    // where each accepted access is (being issued, being answered).
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] exp_q [$];
    bit            grant_log [$];
    bit            last_grant;
    bit            iss_v, iss_we, iss_port, rsp_v, rsp_port;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_wdata;
    logic [DW-1:0] cap_rsp0, cap_rsp1;
    int            seen_rsp0, seen_rsp1, we_cycles;
    int            errors = 0;
    int            checks = 0;

    task automatic do_reset();
        rst_n = 1'b0;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        init_ram = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        ref_mem[5] = 16'hBEEF;
        last_grant = 1'b1;
        iss_v = 1'b0;
        rsp_v = 1'b0;
        hold_addr = '0;
        hold_wdata = '0;
        exp_q.delete();
        grant_log.delete();
        @(negedge clk);
        @(negedge clk);
        init_ram = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic clear_stats();
        seen_rsp0 = 0;
        seen_rsp1 = 0;
        we_cycles = 0;
        cap_rsp0 = 'x;
        cap_rsp1 = 'x;
    endtask

    // One clock cycle: entered just after a falling edge with inputs driven.
    task automatic cycle();
        bit            v0, v1, g, acc0, acc1, wr;
        logic [15:0]   a16;
        logic [DW-1:0] wd, exp_d;
        arb_state_e    exp_st;
        #1;
        if (ram_write_enable) we_cycles++;
        checks++;
        if (ram_write_enable !== (iss_v && iss_we))
            $display("FAIL ram_we: got %b expected %b", ram_write_enable, iss_v && iss_we);
        checks++;
        if (ram_addr !== hold_addr || ram_write_data !== hold_wdata) begin
            errors++;
            $display("FAIL ram_bus: got addr=%h data=%h expected addr=%h data=%h",
                     ram_addr, ram_write_data, hold_addr, hold_wdata);
        end
        if (ram_write_enable !== (iss_v && iss_we)) errors++;
        checks++;
        if (p0_rsp_valid !== (rsp_v && !rsp_port) || p1_rsp_valid !== (rsp_v && rsp_port)) begin
            errors++;
            $display("FAIL rsp_valid: got p0=%b p1=%b expected p0=%b p1=%b",
                     p0_rsp_valid, p1_rsp_valid, rsp_v && !rsp_port, rsp_v && rsp_port);
        end
        if (p0_rsp_valid === 1'b1) begin seen_rsp0++; cap_rsp0 = p0_rsp_data; end
        if (p1_rsp_valid === 1'b1) begin seen_rsp1++; cap_rsp1 = p1_rsp_data; end
        if (rsp_v && exp_q.size() > 0) begin
            exp_d = exp_q.pop_front();
            checks++;
            if ((rsp_port ? p1_rsp_data : p0_rsp_data) !== exp_d) begin
                errors++;
                $display("FAIL rsp_data: port %0d got %h expected %h", rsp_port,
                         rsp_port ? p1_rsp_data : p0_rsp_data, exp_d);
            end
        end
        exp_st = iss_v ? ISSUE : (rsp_v ? RESP : IDLE);
        checks++;
        if (dbg_state !== exp_st) begin
            errors++;
            $display("FAIL state: got %0d expected %0d", dbg_state, exp_st);
        end
        v0 = p0_req_valid;
        v1 = p1_req_valid;
        g = (v0 && v1) ? ~last_grant : v1;
        acc0 = !iss_v && v0 && !g;
        acc1 = !iss_v && v1 && g;
        checks++;
        if (p0_req_ready !== acc0 || p1_req_ready !== acc1) begin
            errors++;
            $display("FAIL ready: got p0=%b p1=%b expected p0=%b p1=%b",
                     p0_req_ready, p1_req_ready, acc0, acc1);
        end
        rsp_v = iss_v;
        rsp_port = iss_port;
        iss_v = acc0 || acc1;
        if (iss_v) begin
            last_grant = g;
            iss_port = g;
            wr  = g ? p1_req_we : p0_req_we;
            a16 = g ? p1_req_addr : p0_req_addr;
            wd  = g ? p1_req_wdata : p0_req_wdata;
            iss_we = wr;
            hold_addr = a16[AW-1:0];
            hold_wdata = wd;
            if (wr) begin
                ref_mem[hold_addr] = wd;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(ref_mem[hold_addr]);
            end
            grant_log.push_back(g);
        end
        @(posedge clk);
        @(negedge clk);
        if (acc0) p0_req_valid = 1'b0;
        if (acc1) p1_req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while ((p0_req_valid || p1_req_valid || iss_v || rsp_v) && n < max_cycles) begin
            cycle();
            n++;
        end
        checks++;
        if (p0_req_valid || p1_req_valid || iss_v || rsp_v) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
            p0_req_valid = 1'b0;
            p1_req_valid = 1'b0;
        end
    endtask

    task automatic drive_p0(input bit we, input logic [15:0] a, input logic [DW-1:0] d);
        p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    endtask

    task automatic drive_p1(input bit we, input logic [15:0] a, input logic [DW-1:0] d);
        p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        check_val("reset_outputs",
                  {22'd0, ram_write_enable, p0_rsp_valid, p1_rsp_valid, dbg_state, p0_req_ready, p1_req_ready, 3'd0},
                  32'd0);
        check_val("reset_bus", {ram_addr, ram_write_data, p0_rsp_data[5:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_p0_read();
        clear_stats();
        drive_p0(1'b0, 16'h0005, 16'h0);
        wait_done(10);
        check_val("p0_read_data", cap_rsp0, 16'hBEEF);
        check_val("p0_read_count", seen_rsp0, 1);
        check_val("p0_read_p1_quiet", seen_rsp1, 0);
    endtask

    task automatic test_p1_write_read();
        clear_stats();
        drive_p1(1'b1, 16'h0010, 16'h1234);
        wait_done(10);
        check_val("p1_write_ack", cap_rsp1, 16'h0);
        check_val("p1_write_we_cycles", we_cycles, 1);
        drive_p1(1'b0, 16'h0010, 16'h0);
        wait_done(10);
        check_val("p1_read_back", cap_rsp1, 16'h1234);
        check_val("p1_rsp_count", seen_rsp1, 2);
    endtask

    task automatic test_alias();
        clear_stats();
        drive_p0(1'b0, 16'h0405, 16'h0);
        wait_done(10);
        check_val("alias_read", cap_rsp0, 16'hBEEF);
    endtask

    task automatic test_alternate();
        int bad = 0;
        do_reset();
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            if (!p0_req_valid) drive_p0(1'b0, 16'h0001, 16'h0);
            if (!p1_req_valid) drive_p1(1'b0, 16'h0002, 16'h0);
            cycle();
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        wait_done(10);
        check_val("alt_grant_count", grant_log.size(), 20);
        for (int i = 0; i < grant_log.size(); i++)
            if (grant_log[i] != (i % 2)) bad++;
        check_val("alt_grant_order", bad, 0);
        check_val("alt_no_starve", {seen_rsp0[15:0], seen_rsp1[15:0]}, {16'd10, 16'd10});
    endtask

    task automatic test_reset_mid();
        int n = 0;
        drive_p1(1'b1, 16'h0020, 16'h5A5A);
        while (!iss_v && n < 5) begin cycle(); n++; end
        check_val("mid_in_issue", {dbg_state == ISSUE, ram_write_enable}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_val("mid_we_drop", ram_write_enable, 1'b0);
        check_val("mid_state", dbg_state, IDLE);
        check_val("mid_outputs", {ram_addr, ram_write_data, p1_rsp_valid, p0_rsp_valid}, 32'd0);
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (p0_rsp_valid === 1'b1 || p1_rsp_valid === 1'b1) seen_rsp1++;
        end
        check_val("mid_no_rsp", seen_rsp1, 0);
        do_reset();
        drive_p0(1'b0, 16'h0005, 16'h0);
        drive_p1(1'b0, 16'h0006, 16'h0);
        wait_done(12);
        check_val("mid_first_tie", {grant_log.size() == 2, grant_log[0]}, 2'b10);
    endtask

    task automatic test_drop_valid();
        grant_log.delete();
        clear_stats();
        drive_p0(1'b0, 16'h0003, 16'h0);
        cycle();
        drive_p1(1'b0, 16'h0007, 16'h0);
        cycle();
        p1_req_valid = 1'b0;
        wait_done(10);
        check_val("drop_no_p1_access", {seen_rsp1[7:0], grant_log.size() == 1}, 9'd1);
        drive_p0(1'b0, 16'h0003, 16'h0);
        drive_p1(1'b0, 16'h0007, 16'h0);
        cycle();
        check_val("drop_ptr_kept", {grant_log.size() == 2, grant_log[grant_log.size()-1]}, 2'b11);
        wait_done(12);
    endtask

    task automatic test_random();
        logic [15:0] a;
        clear_stats();
        for (int i = 0; i < 300; i++) begin
            if (!p0_req_valid && $urandom_range(0, 1)) begin
                a = 16'($urandom);
                a[AW-1:0] = 10'($urandom_range(0, 15));
                drive_p0(1'($urandom), a, 16'($urandom));
            end
            if (!p1_req_valid && $urandom_range(0, 1)) begin
                a = 16'($urandom);
                a[AW-1:0] = 10'($urandom_range(0, 15));
                drive_p1(1'($urandom), a, 16'($urandom));
            end
            cycle();
        end
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        wait_done(10);
        check_val("random_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_p0_read();
        test_p1_write_read();
        test_alias();
        test_drop_valid();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
